lsu: RTL and testbench

Load/store unit in the hxd32 execute stage. It sits directly downstream of the ALU and uses the ALU result as the effective address.
- Runs one data-bus transaction per memory instruction over a req/gnt/rvalid bus.
- Forms byte enables and replicated store data.
- Aligns and sign- or zero-extends load data.
- Stalls the pipeline until the access completes.

---
 rtl/lsu.sv | 133 +++++++++++++
 tb/tb_lsu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - hxd32 load/store unit: one req/gnt/rvalid bus access per memory op
module lsu #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wr_data_i,
    output logic [XLEN-1:0]   lsu_rd_data_o,
    output logic              lsu_done_o,
    output logic              lsu_stall_o,
    output logic              lsu_misalign_o,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [XLEN-1:0]   dbus_addr_o,
    output logic [XLEN/8-1:0] dbus_be_o,
    output logic [XLEN-1:0]   dbus_wr_data_o,
    input  logic              dbus_gnt_i,
    input  logic              dbus_rvalid_i,
    input  logic [XLEN-1:0]   dbus_rd_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [2:0]          r_size;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN/8-1:0]   r_be;
    logic [XLEN-1:0]     r_wdata;
    logic [XLEN-1:0]     r_rd_data;
    logic                r_mis;

    logic                w_bad;
    logic [XLEN/8-1:0]   w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_shifted;
    logic [XLEN-1:0]     w_ext;

    // Legal funct3: 000, 001, 010, 100, 101; everything else is rejected without a bus access.
    always_comb begin
        w_bad = 1'b0;
        case (lsu_size_i)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = lsu_addr_i[0];
            3'b010:         w_bad = (lsu_addr_i[1:0] != 2'b00);
            default:        w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = lsu_wr_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_wr_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << lsu_addr_i[1:0];
                w_wdata = {2{lsu_wr_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = dbus_rd_data_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ext = w_shifted;
        case (r_size)
            3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_ext = {24'd0, w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_ext = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (lsu_req_i) w_next = w_bad ? S_DONE : S_REQ;
            S_REQ:  if (dbus_gnt_i) w_next = r_we ? S_DONE : S_WAIT;
            S_WAIT: if (dbus_rvalid_i) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_size    <= 3'b000;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_mis     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && lsu_req_i) begin
                r_mis <= w_bad;
                if (!w_bad) begin
                    r_we    <= lsu_we_i;
                    r_size  <= lsu_size_i;
                    r_addr  <= lsu_addr_i;
                    r_be    <= w_be;
                    r_wdata <= w_wdata;
                end
            end
            if (r_state == S_WAIT && dbus_rvalid_i) begin
                r_rd_data <= w_ext;
            end
        end
    end

    assign lsu_rd_data_o  = r_rd_data;
    assign lsu_done_o     = (r_state == S_DONE);
    assign lsu_misalign_o = (r_state == S_DONE) && r_mis;
    assign lsu_stall_o    = lsu_req_i && !lsu_done_o;
    assign dbus_req_o     = (r_state == S_REQ);
    assign dbus_we_o      = r_we;
    assign dbus_addr_o    = {r_addr[XLEN-1:2], 2'b00};
    assign dbus_be_o      = r_be;
    assign dbus_wr_data_o = r_wdata;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed vector bench for lsu
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wr_data_i;
    logic [31:0] lsu_rd_data_o;
    logic        lsu_done_o;
    logic        lsu_stall_o;
    logic        lsu_misalign_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wr_data_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rd_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    lsu #(.XLEN(32)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wr_data_i  (lsu_wr_data_i),
        .lsu_rd_data_o  (lsu_rd_data_o),
        .lsu_done_o     (lsu_done_o),
        .lsu_stall_o    (lsu_stall_o),
        .lsu_misalign_o (lsu_misalign_o),
        .dbus_req_o     (dbus_req_o),
        .dbus_we_o      (dbus_we_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_be_o      (dbus_be_o),
        .dbus_wr_data_o (dbus_wr_data_o),
        .dbus_gnt_i     (dbus_gnt_i),
        .dbus_rvalid_i  (dbus_rvalid_i),
        .dbus_rd_data_i (dbus_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_mis;
        int          e_lat;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        int  rq;
        bit  pend;
        bit  done;
        bit  saw_req;
        lsu_req_i     = 1'b1;
        lsu_we_i      = v.we;
        lsu_size_i    = v.size;
        lsu_addr_i    = v.addr;
        lsu_wr_data_i = v.wdata;
        cyc = 0; rq = 0; pend = 0; done = 0; saw_req = 0;
        while (!done && cyc < 30) begin
            step();
            cyc++;
            dbus_gnt_i    = 1'b0;
            dbus_rvalid_i = 1'b0;
            if (pend) begin
                dbus_rvalid_i  = 1'b1;
                dbus_rd_data_i = v.rdata;
                pend = 0;
            end
            check($sformatf("v%0d stall c%0d", idx, cyc), 32'(lsu_stall_o), 32'(cyc != v.e_lat));
            if (lsu_done_o) begin
                done = 1;
                check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.e_lat));
                check($sformatf("v%0d misalign", idx), 32'(lsu_misalign_o), 32'(v.e_mis));
                check($sformatf("v%0d rd_data", idx), lsu_rd_data_o, v.e_rd);
                check($sformatf("v%0d bus_seen", idx), 32'(saw_req), 32'(!v.e_mis));
            end else if (dbus_req_o) begin
                saw_req = 1;
                check($sformatf("v%0d addr c%0d", idx, cyc), dbus_addr_o, v.e_addr);
                check($sformatf("v%0d be c%0d", idx, cyc), 32'(dbus_be_o), 32'(v.e_be));
                check($sformatf("v%0d wdata c%0d", idx, cyc), dbus_wr_data_o, v.e_wdata);
                check($sformatf("v%0d we c%0d", idx, cyc), 32'(dbus_we_o), 32'(v.we));
                if (rq == v.gnt_dly) begin
                    dbus_gnt_i = 1'b1;
                    if (!v.we) pend = 1;
                end
                rq++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d timeout: got no done expected done", idx);
        end
        lsu_req_i = 1'b0;
        step();
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        check($sformatf("v%0d done_pulse_width", idx), 32'(lsu_done_o), 32'd0);
        check($sformatf("v%0d stall_after", idx), 32'(lsu_stall_o), 32'd0);
    endtask

    initial begin
        //          we    size    addr          wdata         rdata         gd  e_addr        e_be     e_wdata       e_rd          mis   lat
        vt[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 2};
        vt[1]  = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,        3, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 5};
        vt[2]  = '{1'b0, 3'b000, 32'h0000_0302, 32'h0,         32'h12F4_5678, 0, 32'h0000_0300, 4'b0100, 32'h0,        32'hFFFF_FFF4, 1'b0, 3};
        vt[3]  = '{1'b0, 3'b100, 32'h0000_0302, 32'h0,         32'h12F4_5678, 0, 32'h0000_0300, 4'b0100, 32'h0,        32'h0000_00F4, 1'b0, 3};
        vt[4]  = '{1'b0, 3'b001, 32'h0000_0402, 32'h0,         32'h8001_1234, 0, 32'h0000_0400, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 3};
        vt[5]  = '{1'b0, 3'b101, 32'h0000_0402, 32'h0,         32'h8001_1234, 0, 32'h0000_0400, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 3};
        vt[6]  = '{1'b0, 3'b010, 32'h0000_0506, 32'h0,         32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'h0000_8001, 1'b1, 1};
        vt[7]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'h0000_8001, 1'b1, 1};
        vt[8]  = '{1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 32'h0,        1, 32'h0000_0010, 4'b1100, 32'hABCD_ABCD, 32'h0000_8001, 1'b0, 3};
        vt[9]  = '{1'b0, 3'b010, 32'h0000_0600, 32'h0,         32'hCAFE_F00D, 2, 32'h0000_0600, 4'b1111, 32'h0,        32'hCAFE_F00D, 1'b0, 5};
        vt[10] = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,         32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'hCAFE_F00D, 1'b1, 1};

        rst_n_i        = 1'b0;
        lsu_req_i      = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_size_i     = 3'b000;
        lsu_addr_i     = 32'h0;
        lsu_wr_data_i  = 32'h0;
        dbus_gnt_i     = 1'b0;
        dbus_rvalid_i  = 1'b0;
        dbus_rd_data_i = 32'h0;
        step();
        step();
        check("rst done", 32'(lsu_done_o), 32'd0);
        check("rst misalign", 32'(lsu_misalign_o), 32'd0);
        check("rst stall", 32'(lsu_stall_o), 32'd0);
        check("rst rd_data", lsu_rd_data_o, 32'h0);
        check("rst dbus_req", 32'(dbus_req_o), 32'd0);
        check("rst dbus_we", 32'(dbus_we_o), 32'd0);
        check("rst dbus_addr", dbus_addr_o, 32'h0);
        check("rst dbus_be", 32'(dbus_be_o), 32'd0);
        check("rst dbus_wdata", dbus_wr_data_o, 32'h0);
        rst_n_i = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            run_vec(vt[i], i);
        end

        // Reset while a load sits in WAIT, then a stray rvalid after reset.
        lsu_req_i     = 1'b1;
        lsu_we_i      = 1'b0;
        lsu_size_i    = 3'b010;
        lsu_addr_i    = 32'h0000_0700;
        lsu_wr_data_i = 32'h0;
        step();
        check("rstw req_in_req", 32'(dbus_req_o), 32'd1);
        dbus_gnt_i = 1'b1;
        step();
        dbus_gnt_i = 1'b0;
        check("rstw req_dropped_wait", 32'(dbus_req_o), 32'd0);
        check("rstw no_done_wait", 32'(lsu_done_o), 32'd0);
        rst_n_i   = 1'b0;
        lsu_req_i = 1'b0;
        step();
        rst_n_i        = 1'b1;
        check("rstw rd_data_cleared", lsu_rd_data_o, 32'h0);
        check("rstw no_done_rst", 32'(lsu_done_o), 32'd0);
        check("rstw req_low_rst", 32'(dbus_req_o), 32'd0);
        dbus_rvalid_i  = 1'b1;
        dbus_rd_data_i = 32'h1357_9BDF;
        step();
        dbus_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstw stray_done c%0d", k), 32'(lsu_done_o), 32'd0);
            check($sformatf("rstw stray_rd c%0d", k), lsu_rd_data_o, 32'h0);
            check($sformatf("rstw stray_req c%0d", k), 32'(dbus_req_o), 32'd0);
            step();
        end

        // The FSM must be back in IDLE and accept a fresh store with minimum latency.
        run_vec('{1'b1, 3'b010, 32'h0000_0800, 32'h0BAD_F00D, 32'h0, 0, 32'h0000_0800, 4'b1111, 32'h0BAD_F00D, 32'h0, 1'b0, 2}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
